// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-2^R multiplier: state encoding,
// iteration sizing and the signed-magnitude helper.
package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int iter_f(input int bw, input int r);
        return bw / r;
    endfunction

    // One spare bit so the counter can represent ITER itself.
    function automatic int cnt_w_f(input int bw, input int r);
        return $clog2(bw / r) + 1;
    endfunction

    // Magnitude of a bw-bit value; -2^(bw-1) maps to 2^(bw-1), which still fits unsigned.
    function automatic logic [63:0] mag_f(input logic [63:0] v, input int bw, input logic sgn);
        logic [63:0] mask_s;
        mask_s = (64'd1 << bw) - 64'd1;
        if (sgn && v[bw-1]) begin
            return (~v + 64'd1) & mask_s;
        end else begin
            return v & mask_s;
        end
    endfunction

endpackage

// File: rtl/mul_radix_step.sv
// One shift-add step: adds digit*amag, weighted by 2^(idx*R), into the
// 2*BW-bit accumulator; the carry-out is dropped.
module mul_radix_step #(
    parameter int BW = 16,
    parameter int R  = 2,
    parameter int SW = 4
) (
    input  logic [2*BW-1:0] acc,
    input  logic [BW-1:0]   amag,
    input  logic [R-1:0]    digit,
    input  logic [SW-1:0]   idx,
    output logic [2*BW-1:0] acc_next
);

    logic [2*BW-1:0] prod_s;

    // Partial product in full product width, then positioned and accumulated.
    always_comb begin
        prod_s   = {{BW{1'b0}}, amag} * {{(2*BW-R){1'b0}}, digit};
        acc_next = acc + (prod_s << (32'(idx) * R));
    end

endmodule

// File: rtl/mul_seq_radix.sv
// Multi-cycle shift-add multiplier retiring R multiplier bits per cycle, with
// signed/unsigned operands and valid/ready handshakes on both sides.
module mul_seq_radix
    import mul_pkg::*;
#(
    parameter int BW = 16,
    parameter int R  = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BW-1:0]   A,
    input  logic [BW-1:0]   B,
    input  logic            is_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*BW-1:0] out,
    output logic            busy
);

    localparam int ITER = iter_f(BW, R);
    localparam int CW   = cnt_w_f(BW, R);

    if ((R < 1) || (BW % R != 0)) begin : g_bad_radix
        $error("mul_seq_radix: R must divide BW");
    end
    if (BW > 32) begin : g_bad_width
        $error("mul_seq_radix: BW must not exceed 32");
    end

    state_e          state_r, state_nxt_s;
    logic [BW-1:0]   amag_r, amag_nxt_s;
    logic [BW-1:0]   bsh_r, bsh_nxt_s;
    logic            neg_r, neg_nxt_s;
    logic [2*BW-1:0] acc_r, acc_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic [2*BW-1:0] out_r, out_nxt_s;
    logic            in_ready_r, out_valid_r, busy_r;
    logic [2*BW-1:0] step_acc_s;
    logic [BW-1:0]   amag_in_s, bmag_in_s;
    logic [63-BW:0]  mag_a_unused_s, mag_b_unused_s;

    assign {mag_a_unused_s, amag_in_s} = mag_f(64'(A), BW, is_signed);
    assign {mag_b_unused_s, bmag_in_s} = mag_f(64'(B), BW, is_signed);

    mul_radix_step #(
        .BW (BW),
        .R  (R),
        .SW (CW)
    ) u_step (
        .acc      (acc_r),
        .amag     (amag_r),
        .digit    (bsh_r[R-1:0]),
        .idx      (cnt_r),
        .acc_next (step_acc_s)
    );

    // Next-state and datapath updates; operands are only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        amag_nxt_s  = amag_r;
        bsh_nxt_s   = bsh_r;
        neg_nxt_s   = neg_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        out_nxt_s   = out_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    amag_nxt_s  = amag_in_s;
                    bsh_nxt_s   = bmag_in_s;
                    neg_nxt_s   = is_signed & (A[BW-1] ^ B[BW-1]);
                    acc_nxt_s   = '0;
                    cnt_nxt_s   = '0;
                    state_nxt_s = S_BUSY;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_BUSY: begin
                acc_nxt_s = step_acc_s;
                bsh_nxt_s = bsh_r >> R;
                cnt_nxt_s = cnt_r + CW'(1);
                if (cnt_r == CW'(ITER - 1)) begin
                    out_nxt_s   = neg_r ? ((2*BW)'(0) - step_acc_s) : step_acc_s;
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= S_IDLE;
            amag_r      <= '0;
            bsh_r       <= '0;
            neg_r       <= 1'b0;
            acc_r       <= '0;
            cnt_r       <= '0;
            out_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            amag_r      <= amag_nxt_s;
            bsh_r       <= bsh_nxt_s;
            neg_r       <= neg_nxt_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_r       <= out_nxt_s;
            in_ready_r  <= (state_nxt_s == S_IDLE);
            out_valid_r <= (state_nxt_s == S_DONE);
            busy_r      <= (state_nxt_s == S_BUSY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out       = out_r;

endmodule

// File: tb/tb_mul_seq_radix.sv
// Scoreboard bench for mul_seq_radix (BW=16, R=2): directed vectors, backpressure,
// mid-operation reset and a short random run against a reference product.
module tb_mul_seq_radix;

    localparam int BW   = 16;
    localparam int R    = 2;
    localparam int ITER = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = 16'h0000;
    logic [15:0] B = 16'h0000;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        busy;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    typedef struct {
        logic [31:0] prod;
        longint      acc_cyc;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    mul_seq_radix #(.BW(BW), .R(R)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic flag(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event, expected none", nm);
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [31:0] xa, xb;
        xa = s ? {{16{a[15]}}, a} : {16'h0000, a};
        xb = s ? {{16{b[15]}}, b} : {16'h0000, b};
        return xa * xb;
    endfunction

    // Monitor: latency on out_valid rising, product on each output transfer.
    logic prev_valid = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && out_valid && !prev_valid) begin
            if (sb_q.size() == 0) flag("unexpected_valid");
            else check({sb_q[0].name, "_latency"}, 64'(cyc - sb_q[0].acc_cyc), 64'(ITER));
        end
        if (!RESET && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                flag("spurious_output");
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_out"}, 64'(out), 64'(e.prod));
            end
        end
        prev_valid = out_valid;
    end

    // Issue one operand set; called and returns on a falling edge.
    task automatic txn(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [31:0] expv, input string nm);
        exp_t e;
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!in_ready) begin
            flag({nm, "_in_ready_timeout"});
            return;
        end
        A = a; B = b; is_signed = s; in_valid = 1'b1;
        e.prod = expv; e.acc_cyc = cyc + 1; e.name = nm;
        sb_q.push_back(e);
        @(negedge CLK);
        in_valid = 1'b0;
        A = 16'hxxxx;
        B = 16'hxxxx;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (sb_q.size() != 0) begin
            flag({nm, "_drain_timeout"});
            sb_q.delete();
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        int          t;

        repeat (2) @(negedge CLK);
        check("reset_out", 64'(out), 64'h0);
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_in_ready", 64'(in_ready), 64'h1);
        check("reset_busy", 64'(busy), 64'h0);
        RESET = 1'b0;
        @(negedge CLK);

        txn(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_ffff_ffff");
        check("busy_after_accept", 64'(busy), 64'h1);
        check("in_ready_while_busy", 64'(in_ready), 64'h0);
        drain("u_ffff_ffff");
        @(negedge CLK);
        check("in_ready_after_done", 64'(in_ready), 64'h1);
        check("out_valid_after_done", 64'(out_valid), 64'h0);

        txn(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, "s_m3_5");
        txn(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_min_min");
        txn(16'h8000, 16'h8000, 1'b0, 32'h40000000, "u_8000_8000");
        txn(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, "s_min_1");
        txn(16'hFFFF, 16'h0000, 1'b1, 32'h00000000, "s_neg_zero");
        txn(16'h0000, 16'h0000, 1'b0, 32'h00000000, "u_zero");
        drain("directed");

        // Backpressure: hold the result for 5 cycles while poking in_valid.
        out_ready = 1'b0;
        txn(16'h1234, 16'h0010, 1'b0, 32'h00012340, "bp");
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (!out_valid) flag("bp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            check("bp_out_stable", 64'(out), 64'h00012340);
            check("bp_in_ready_low", 64'(in_ready), 64'h0);
            check("bp_out_valid_held", 64'(out_valid), 64'h1);
            in_valid = i[0];
            A = 16'hFFFF;
            B = 16'hFFFF;
            @(negedge CLK);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        check("bp_release_valid", 64'(out_valid), 64'h0);
        check("bp_release_in_ready", 64'(in_ready), 64'h1);
        check("bp_out_held_idle", 64'(out), 64'h00012340);
        drain("bp");

        // Reset in the middle of BUSY discards the pending result.
        txn(16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, "rst_mid");
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        sb_q.delete();
        @(negedge CLK);
        RESET = 1'b0;
        check("rst_mid_out", 64'(out), 64'h0);
        check("rst_mid_out_valid", 64'(out_valid), 64'h0);
        check("rst_mid_in_ready", 64'(in_ready), 64'h1);
        check("rst_mid_busy", 64'(busy), 64'h0);
        txn(16'h0003, 16'h0007, 1'b0, 32'd21, "post_rst");
        drain("post_rst");

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(1, 0));
            txn(ra, rb, rs, ref_mul(ra, rb, rs), "rnd");
        end
        drain("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
